// File: rtl/reg_native_if_pkg.sv
// reg_native_if_pkg: shared types and constants for the native-interface bridges.
package reg_native_if_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int TO_CNT_W = 16;
    localparam logic [31:0] TIMEOUT_RDATA_DEF = 32'hDEAD_BEEF;
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/reg_native_if_timeout_timer.sv
// reg_native_if_timeout_timer: wait counter that flags the last allowed cycle; LIMIT=0 never expires.
module reg_native_if_timeout_timer
    import reg_native_if_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (en && !(&cnt_q)) ? cnt_q + TO_CNT_W'(1) : cnt_q;
    assign expire = en && (LIMIT != 0) && (cnt_q == TO_CNT_W'(LIMIT - 1));
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/reg_native_if_fwd_mux.sv
// reg_native_if_fwd_mux: forwards one regdisp request to an address-selected
// third-party port and returns its data, or a defined error/timeout response.
module reg_native_if_fwd_mux
    import reg_native_if_pkg::*;
#(
    parameter int EXT_NUM = 3,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 64,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [BUS_DATA_WIDTH-1:0] TIMEOUT_RDATA = BUS_DATA_WIDTH'(TIMEOUT_RDATA_DEF)
) (
    input  logic                              native_clk,
    input  logic                              native_rst,
    input  logic                              req_vld,
    output logic                              ack_vld,
    input  logic [BUS_ADDR_WIDTH-1:0]         addr,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic [BUS_DATA_WIDTH-1:0]         wr_data,
    output logic [BUS_DATA_WIDTH-1:0]         rd_data,
    output logic [EXT_NUM-1:0]                ext_req_vld,
    input  logic [EXT_NUM-1:0]                ext_ack_vld,
    output logic [BUS_ADDR_WIDTH-1:0]         ext_addr,
    output logic                              ext_wr_en,
    output logic                              ext_rd_en,
    output logic [BUS_DATA_WIDTH-1:0]         ext_wr_data,
    input  logic [EXT_NUM*BUS_DATA_WIDTH-1:0] ext_rd_data,
    output logic                              err_pulse,
    output logic [TO_CNT_W-1:0]               timeout_cnt
);
    localparam int SEL_W = sel_w(EXT_NUM);
    localparam int DW = BUS_DATA_WIDTH;

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [EXT_NUM-1:0]    ext_req_vld_q, ext_req_vld_d;
    logic [BUS_ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
    logic                  ext_wr_en_q, ext_wr_en_d, ext_rd_en_q, ext_rd_en_d;
    logic [DW-1:0]         ext_wr_data_q, ext_wr_data_d, rd_data_q, rd_data_d;
    logic                  ack_vld_q, ack_vld_d, err_pulse_q, err_pulse_d;
    logic [TO_CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;

    logic [SEL_W-1:0] sel;
    logic             legal, ack_sel, expire;
    logic [DW-1:0]    rd_sel;

    assign sel     = addr[SEL_LSB +: SEL_W];
    assign legal   = (wr_en ^ rd_en) && (int'(sel) < EXT_NUM);
    // Only the addressed port may complete the transaction.
    assign ack_sel = ext_ack_vld[sel_q];
    assign rd_sel  = ext_rd_data[int'(sel_q) * DW +: DW];

    reg_native_if_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk    (native_clk),
        .rst    (native_rst),
        .clr    (state_q == IDLE),
        .en     (state_q == WAIT && !ack_sel),
        .expire (expire)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        ext_req_vld_d = '0;
        ext_addr_d    = ext_addr_q;
        ext_wr_en_d   = ext_wr_en_q;
        ext_rd_en_d   = ext_rd_en_q;
        ext_wr_data_d = ext_wr_data_q;
        rd_data_d     = rd_data_q;
        ack_vld_d     = 1'b0;
        err_pulse_d   = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
        case (state_q)
            IDLE: if (req_vld) begin
                if (legal) begin
                    sel_d         = sel;
                    ext_req_vld_d = EXT_NUM'(1) << sel;
                    ext_addr_d    = addr;
                    ext_wr_en_d   = wr_en;
                    ext_rd_en_d   = rd_en;
                    ext_wr_data_d = wr_data;
                    state_d       = WAIT;
                end else begin
                    rd_data_d   = TIMEOUT_RDATA;
                    ack_vld_d   = 1'b1;
                    err_pulse_d = 1'b1;
                    state_d     = RESP;
                end
            end
            WAIT: if (ack_sel) begin
                rd_data_d = ext_rd_en_q ? rd_sel : '0;
                ack_vld_d = 1'b1;
                state_d   = RESP;
            end else if (expire) begin
                rd_data_d     = TIMEOUT_RDATA;
                ack_vld_d     = 1'b1;
                err_pulse_d   = 1'b1;
                timeout_cnt_d = (&timeout_cnt_q) ? timeout_cnt_q : timeout_cnt_q + 16'd1;
                state_d       = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge native_clk) begin
        if (native_rst) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            ext_req_vld_q <= '0;
            ext_addr_q    <= '0;
            ext_wr_en_q   <= 1'b0;
            ext_rd_en_q   <= 1'b0;
            ext_wr_data_q <= '0;
            rd_data_q     <= '0;
            ack_vld_q     <= 1'b0;
            err_pulse_q   <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            ext_req_vld_q <= ext_req_vld_d;
            ext_addr_q    <= ext_addr_d;
            ext_wr_en_q   <= ext_wr_en_d;
            ext_rd_en_q   <= ext_rd_en_d;
            ext_wr_data_q <= ext_wr_data_d;
            rd_data_q     <= rd_data_d;
            ack_vld_q     <= ack_vld_d;
            err_pulse_q   <= err_pulse_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign ext_req_vld = ext_req_vld_q;
    assign ext_addr    = ext_addr_q;
    assign ext_wr_en   = ext_wr_en_q;
    assign ext_rd_en   = ext_rd_en_q;
    assign ext_wr_data = ext_wr_data_q;
    assign rd_data     = rd_data_q;
    assign ack_vld     = ack_vld_q;
    assign err_pulse   = err_pulse_q;
    assign timeout_cnt = timeout_cnt_q;
endmodule

// File: tb/tb_reg_native_if_fwd_mux.sv
// tb_reg_native_if_fwd_mux: directed bench for the forwarding mux, built with an 8-cycle timeout.
module tb_reg_native_if_fwd_mux;
    logic        native_clk = 1'b0;
    logic        native_rst = 1'b1;
    logic        req_vld = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [63:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic        ack_vld, ext_wr_en, ext_rd_en, err_pulse;
    logic [31:0] rd_data, ext_wr_data;
    logic [2:0]  ext_req_vld;
    logic [2:0]  ext_ack_vld = '0;
    logic [63:0] ext_addr;
    logic [95:0] ext_rd_data = '0;
    logic [15:0] timeout_cnt;
    int checks = 0, failures = 0;

    always #5 native_clk = ~native_clk;

    reg_native_if_fwd_mux #(
        .EXT_NUM(3), .BUS_DATA_WIDTH(32), .BUS_ADDR_WIDTH(64),
        .SEL_LSB(12), .TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEAD_BEEF)
    ) dut (
        .native_clk(native_clk), .native_rst(native_rst), .req_vld(req_vld), .ack_vld(ack_vld),
        .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data), .rd_data(rd_data),
        .ext_req_vld(ext_req_vld), .ext_ack_vld(ext_ack_vld), .ext_addr(ext_addr),
        .ext_wr_en(ext_wr_en), .ext_rd_en(ext_rd_en), .ext_wr_data(ext_wr_data),
        .ext_rd_data(ext_rd_data), .err_pulse(err_pulse), .timeout_cnt(timeout_cnt)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge native_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic w, input logic r, input logic [31:0] d);
        addr = a; wr_en = w; rd_en = r; wr_data = d; req_vld = 1'b1;
    endtask

    task automatic idle_req();
        req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    endtask

    initial begin
        ext_rd_data[0  +: 32] = 32'h0A0A_0A0A;
        ext_rd_data[32 +: 32] = 32'h1111_1111;
        ext_rd_data[64 +: 32] = 32'h2222_2222;
        step(2);
        chk("rst_ack_vld", 64'(ack_vld), 64'h0);
        chk("rst_ext_req_vld", 64'(ext_req_vld), 64'h0);
        chk("rst_ext_addr", ext_addr, 64'h0);
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        chk("rst_err_pulse", 64'(err_pulse), 64'h0);
        chk("rst_timeout_cnt", 64'(timeout_cnt), 64'h0);
        native_rst = 1'b0;
        step();

        // Read on port 2, ack at cycle 4
        issue(64'h2004, 1'b0, 1'b1, 32'h0);
        step();
        chk("rd2_ext_req_vld", 64'(ext_req_vld), 64'h4);
        chk("rd2_ext_addr", ext_addr, 64'h2004);
        chk("rd2_ext_rd_en", 64'(ext_rd_en), 64'h1);
        chk("rd2_no_early_ack", 64'(ack_vld), 64'h0);
        idle_req();
        step();
        chk("rd2_req_one_cycle", 64'(ext_req_vld), 64'h0);
        step(2);
        ext_rd_data[64 +: 32] = 32'h1234_5678;
        ext_ack_vld = 3'b100;
        step();
        ext_ack_vld = 3'b000;
        chk("rd2_ack_vld", 64'(ack_vld), 64'h1);
        chk("rd2_rd_data", 64'(rd_data), 64'h1234_5678);
        chk("rd2_err_pulse", 64'(err_pulse), 64'h0);
        chk("rd2_addr_stable", ext_addr, 64'h2004);
        step();
        chk("rd2_ack_one_cycle", 64'(ack_vld), 64'h0);

        // Write on port 0, ack together with ext_req_vld
        issue(64'h0010, 1'b1, 1'b0, 32'hA5A5_A5A5);
        step();
        chk("wr0_ext_req_vld", 64'(ext_req_vld), 64'h1);
        chk("wr0_ext_wr_data", 64'(ext_wr_data), 64'hA5A5_A5A5);
        chk("wr0_ext_wr_en", 64'(ext_wr_en), 64'h1);
        idle_req();
        ext_ack_vld = 3'b001;
        step();
        ext_ack_vld = 3'b000;
        chk("wr0_ack_vld", 64'(ack_vld), 64'h1);
        chk("wr0_rd_data_zero", 64'(rd_data), 64'h0);
        chk("wr0_err_pulse", 64'(err_pulse), 64'h0);
        step();

        // Decode error: sel=3
        issue(64'h3000, 1'b0, 1'b1, 32'h0);
        step();
        chk("dec_ack_vld", 64'(ack_vld), 64'h1);
        chk("dec_rd_data", 64'(rd_data), 64'hDEAD_BEEF);
        chk("dec_err_pulse", 64'(err_pulse), 64'h1);
        chk("dec_no_ext_req", 64'(ext_req_vld), 64'h0);
        chk("dec_addr_kept", ext_addr, 64'h0010);
        idle_req();
        step();
        chk("dec_ack_one_cycle", 64'(ack_vld), 64'h0);
        chk("dec_err_one_cycle", 64'(err_pulse), 64'h0);
        step();

        // Illegal: wr_en and rd_en both set
        issue(64'h1000, 1'b1, 1'b1, 32'h0);
        step();
        chk("both_ack_vld", 64'(ack_vld), 64'h1);
        chk("both_rd_data", 64'(rd_data), 64'hDEAD_BEEF);
        chk("both_err_pulse", 64'(err_pulse), 64'h1);
        chk("both_no_ext_req", 64'(ext_req_vld), 64'h0);
        idle_req();
        step(2);

        // Timeout on port 1, late ack at cycle 12
        issue(64'h1008, 1'b0, 1'b1, 32'h0);
        step();
        chk("to_ext_req_vld", 64'(ext_req_vld), 64'h2);
        idle_req();
        step(7);
        chk("to_no_ack_cycle8", 64'(ack_vld), 64'h0);
        step();
        chk("to_ack_vld", 64'(ack_vld), 64'h1);
        chk("to_rd_data", 64'(rd_data), 64'hDEAD_BEEF);
        chk("to_err_pulse", 64'(err_pulse), 64'h1);
        chk("to_timeout_cnt", 64'(timeout_cnt), 64'h1);
        step(3);
        ext_ack_vld = 3'b010;
        step();
        ext_ack_vld = 3'b000;
        chk("to_late_ack_ignored", 64'(ack_vld), 64'h0);
        step();
        chk("to_late_ack_quiet", 64'(ack_vld), 64'h0);

        // Ack on the exact timeout cycle wins
        ext_rd_data[32 +: 32] = 32'hCAFE_F00D;
        issue(64'h1000, 1'b0, 1'b1, 32'h0);
        step();
        idle_req();
        step(7);
        ext_ack_vld = 3'b010;
        step();
        ext_ack_vld = 3'b000;
        chk("edge_ack_vld", 64'(ack_vld), 64'h1);
        chk("edge_rd_data", 64'(rd_data), 64'hCAFE_F00D);
        chk("edge_err_pulse", 64'(err_pulse), 64'h0);
        chk("edge_timeout_cnt", 64'(timeout_cnt), 64'h1);
        step();

        // Wrong-port ack ignored
        ext_rd_data[32 +: 32] = 32'h1357_9BDF;
        issue(64'h1000, 1'b0, 1'b1, 32'h0);
        step();
        idle_req();
        step();
        ext_ack_vld = 3'b001;
        step();
        ext_ack_vld = 3'b000;
        chk("wp_ignored", 64'(ack_vld), 64'h0);
        step();
        ext_ack_vld = 3'b010;
        step();
        ext_ack_vld = 3'b000;
        chk("wp_ack_vld", 64'(ack_vld), 64'h1);
        chk("wp_rd_data", 64'(rd_data), 64'h1357_9BDF);
        step();

        // Reset at cycle 3 of a WAIT with an ack pending
        issue(64'h2000, 1'b1, 1'b0, 32'h0000_0055);
        step();
        idle_req();
        step(2);
        native_rst = 1'b1;
        ext_ack_vld = 3'b100;
        step();
        chk("rst_mid_ack_vld", 64'(ack_vld), 64'h0);
        chk("rst_mid_ext_addr", ext_addr, 64'h0);
        chk("rst_mid_ext_wr_en", 64'(ext_wr_en), 64'h0);
        chk("rst_mid_ext_wr_data", 64'(ext_wr_data), 64'h0);
        chk("rst_mid_rd_data", 64'(rd_data), 64'h0);
        chk("rst_mid_timeout_cnt", 64'(timeout_cnt), 64'h0);
        chk("rst_mid_ext_req_vld", 64'(ext_req_vld), 64'h0);
        native_rst = 1'b0;
        ext_ack_vld = 3'b000;
        step();
        chk("rst_mid_no_ack", 64'(ack_vld), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_native_if_fwd_mux.md
Name: reg_native_if_fwd_mux

Overview:
Single-clock successor to the native-interface third-party bridge. Accepts one reg_native_if request from regdisp and decodes a target from address bits. It forwards the request to one of EXT_NUM external third-party IP ports and holds the request stable until that port acks. If the port never answers, a timeout supplies a defined response, so regdisp cannot hang on a dead IP. One transaction is outstanding at a time.

Parameters:
EXT_NUM, 3, number of external third-party IP ports (1..16)
BUS_DATA_WIDTH, 32, data width
BUS_ADDR_WIDTH, 64, address width
SEL_LSB, 12, lowest address bit of the target-select field
TIMEOUT_CYCLES, 255, maximum wait cycles for an external ack; 0 disables the timeout
TIMEOUT_RDATA, 32'hDEAD_BEEF, rd_data returned on timeout or error (sized to BUS_DATA_WIDTH)
SEL_W (localparam), max(1,$clog2(EXT_NUM)), width of the select field addr[SEL_LSB +: SEL_W]

Ports:
native_clk  in  1  clock
native_rst  in  1  reset; synchronous, active-high
req_vld  in  1  request pulse from regdisp
ack_vld  out  1  response pulse to regdisp
addr  in  BUS_ADDR_WIDTH  request address
wr_en  in  1  write request
rd_en  in  1  read request
wr_data  in  BUS_DATA_WIDTH  write data
rd_data  out  BUS_DATA_WIDTH  read data; valid with ack_vld
ext_req_vld  out  EXT_NUM  one-hot request pulse per port
ext_ack_vld  in  EXT_NUM  per-port ack
ext_addr  out  BUS_ADDR_WIDTH  shared forwarded address
ext_wr_en  out  1  shared forwarded write enable
ext_rd_en  out  1  shared forwarded read enable
ext_wr_data  out  BUS_DATA_WIDTH  shared forwarded write data
ext_rd_data  in  EXT_NUM*BUS_DATA_WIDTH  per-port read data; port i occupies slice [i*DW +: DW]
err_pulse  out  1  asserted together with any ack_vld carrying a timeout or decode error
timeout_cnt  out  16  saturating count of timeouts since reset

Behaviour:
- Clock and reset: one clock, native_clk. Reset native_rst is synchronous and active-high. All outputs are registered.
- Reset values: every output 0, including ext_addr, ext_wr_en, ext_rd_en, ext_wr_data, rd_data and timeout_cnt.
- FSM states: IDLE, WAIT, RESP.
- IDLE with req_vld=1 and a legal request:
  - Legal means exactly one of wr_en/rd_en is set and sel < EXT_NUM.
  - Latch addr, wr_en, rd_en, wr_data and sel into ext_addr, ext_wr_en, ext_rd_en, ext_wr_data and the sel register.
  - Assert ext_req_vld[sel] for exactly one cycle, the cycle after req_vld. Clear the timer. Go to WAIT.
- IDLE with req_vld=1 and an illegal request (wr_en==rd_en, or sel>=EXT_NUM):
  - No external request is issued.
  - Go to RESP with rd_data=TIMEOUT_RDATA and an error flag set.
- WAIT:
  - Only ext_ack_vld[sel] is sampled; acks from other ports are ignored. An ack in the same cycle as ext_req_vld is accepted.
  - On ack: capture ext_rd_data[sel] for a read, or 0 for a write, then go to RESP.
  - Otherwise the timer increments. If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: rd_data=TIMEOUT_RDATA, error flag set, timeout_cnt increments (saturating at 16'hFFFF), go to RESP.
  - Ack and timeout in the same cycle: the ack wins and no error is raised.
- RESP: assert ack_vld (plus err_pulse if the error flag is set) for one cycle with rd_data, then return to IDLE.
- rd_data holds its value after ack; it is meaningful only while ack_vld=1.
- Latency:
  - Forwarded request: req_vld at cycle 0 gives ext_req_vld at cycle 1.
  - Forwarded response: ext ack at cycle k≥1 gives ack_vld at cycle k+1.
  - Error response: ack_vld at cycle 1.
  - Timeout response: ack_vld at cycle TIMEOUT_CYCLES+1.
- ext_addr, ext_wr_en, ext_rd_en and ext_wr_data stay stable from cycle 1 until the next accepted request.
- req_vld outside IDLE is a protocol violation by regdisp; it is ignored and causes no state change.
- A late ext ack after a timeout, or any ext ack in IDLE, is discarded.
- native_rst mid-transaction: the FSM returns to IDLE and all outputs clear next cycle. Any pending ack is dropped and no ack_vld is produced.

Decomposition:
- Package reg_native_if_pkg holds: the state enum (IDLE, WAIT, RESP); the SEL_W computation function; the 16-bit timeout counter width constant; the default TIMEOUT_RDATA constant.
- One sub-module: reg_native_if_timeout_timer, a parametrised wait counter with clear, enable and expire outputs, reusable by the other bridges.
- The top level contains the FSM, request latch, decode and response mux.

Test Plan:
- Read on port 2 (EXT_NUM=3): req_vld with rd_en=1 and addr=0x2004.
  - Expect ext_req_vld=3'b100 at cycle 1 and ext_addr=0x2004.
  - Ext ack at cycle 4 with data 0x1234_5678 → ack_vld at cycle 5 with rd_data=0x1234_5678 and err_pulse=0.
- Write on port 0, addr 0x0010, wr_data 0xA5A5_A5A5: ext ack in the same cycle as ext_req_vld (cycle 1).
  - Expect ack_vld at cycle 2 with rd_data=0 and ext_wr_data=0xA5A5_A5A5.
- Decode error: addr=0x3000 gives sel=3.
  - Expect no ext_req_vld, and ack_vld at cycle 1 with rd_data=0xDEAD_BEEF and err_pulse=1.
  - Same response for wr_en=rd_en=1.
- Timeout with TIMEOUT_CYCLES=8: port 1 never acks.
  - Expect ack_vld at cycle 9 with rd_data=0xDEAD_BEEF, err_pulse=1, timeout_cnt=1.
  - A late ack at cycle 12 is ignored.
- Ack on the exact timeout cycle (ack at cycle 8): expect normal data, err_pulse=0, timeout_cnt unchanged.
- Wrong-port ack and reset:
  - With sel=1, an ack on port 0 is ignored; the transaction completes only on the port 1 ack.
  - native_rst at cycle 3 of a WAIT gives all outputs 0 at cycle 4 and no ack_vld.
